// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline-control sequencer for the 5-stage RV32 core: resolves memory waits, traps,
// taken branches, load-use hazards and fetch misses into PC / pipeline-register controls.
module pipeline_hazard_sequencer #(
    parameter int TRAP_DRAIN_CYCLES = 3,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    input  logic             imem_valid,
    input  logic             trap_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       pc_sel,
    output logic             trap_ack,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DW = (TRAP_DRAIN_CYCLES < 1) ? 1 : $clog2(TRAP_DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        BOOT       = 3'd0,
        RUN        = 3'd1,
        LOAD_STALL = 3'd2,
        MEM_WAIT   = 3'd3,
        TRAP_DRAIN = 3'd4,
        TRAP_JUMP  = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [DW-1:0]   drain_r;
    logic [DW-1:0]   drain_nxt_s;
    logic [CNT_W-1:0] stall_r;
    logic            run_eval_s;
    logic            lu_mask_s;

    assign state        = state_r;
    assign stall_cycles = stall_r;

    // Next-state and Mealy control outputs; RUN evaluation is shared by RUN, LOAD_STALL and MEM_WAIT exit.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pc_sel      = 2'b00;
        trap_ack    = 1'b0;
        state_nxt_s = state_r;
        drain_nxt_s = drain_r;
        run_eval_s  = 1'b0;
        lu_mask_s   = 1'b0;

        case (state_r)
            BOOT: begin
                pc_write    = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                state_nxt_s = RUN;
            end
            RUN: begin
                run_eval_s = 1'b1;
            end
            LOAD_STALL: begin
                run_eval_s = 1'b1;
                lu_mask_s  = 1'b1;
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    state_nxt_s = MEM_WAIT;
                end else begin
                    run_eval_s = 1'b1;
                end
            end
            TRAP_DRAIN: begin
                if (dmem_busy) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    drain_nxt_s = drain_r - {{(DW-1){1'b0}}, 1'b1};
                    // A counter already at 0 or 1 finishes this cycle.
                    if (drain_r <= {{(DW-1){1'b0}}, 1'b1}) begin
                        drain_nxt_s = {DW{1'b0}};
                        state_nxt_s = TRAP_JUMP;
                    end else begin
                        state_nxt_s = TRAP_DRAIN;
                    end
                end
            end
            TRAP_JUMP: begin
                pc_sel      = 2'b10;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                trap_ack    = 1'b1;
                state_nxt_s = RUN;
            end
            default: begin
                pc_write    = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                state_nxt_s = BOOT;
            end
        endcase

        if (run_eval_s) begin
            if (dmem_busy) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                state_nxt_s = MEM_WAIT;
            end else if (trap_req) begin
                pc_write    = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                drain_nxt_s = DW'(TRAP_DRAIN_CYCLES);
                state_nxt_s = TRAP_DRAIN;
            end else if (branch_taken) begin
                pc_sel      = 2'b01;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                state_nxt_s = RUN;
            end else if (load_use && !lu_mask_s) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_flush  = 1'b1;
                state_nxt_s = LOAD_STALL;
            end else if (!imem_valid) begin
                pc_write    = 1'b0;
                ifid_flush  = 1'b1;
                state_nxt_s = RUN;
            end else begin
                state_nxt_s = RUN;
            end
        end else begin
            lu_mask_s = 1'b0;
        end
    end

    // State, drain counter and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= BOOT;
            drain_r <= {DW{1'b0}};
            stall_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            drain_r <= drain_nxt_s;
            if ((state_r != BOOT) && !pc_write && (stall_r != {CNT_W{1'b1}})) begin
                stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench for pipeline_hazard_sequencer: directed vectors push expectations,
// a negedge monitor pops and compares them against two DUTs (CNT_W=16 and CNT_W=4).
module tb_pipeline_hazard_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use = 1'b0, branch_taken = 1'b0, dmem_busy = 1'b0;
    logic imem_valid = 1'b1, trap_req = 1'b0;

    logic        pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, trap_ack;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic [15:0] stall_cycles;

    logic        pc_write2, ifid_write2, idex_write2, exmem_write2, ifid_flush2, idex_flush2, trap_ack2;
    logic [1:0]  pc_sel2;
    logic [2:0]  state2;
    logic [3:0]  stall_cycles2;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(.TRAP_DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
        .dmem_busy(dmem_busy), .imem_valid(imem_valid), .trap_req(trap_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pc_sel(pc_sel), .trap_ack(trap_ack), .state(state), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_sequencer #(.TRAP_DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
        .dmem_busy(dmem_busy), .imem_valid(imem_valid), .trap_req(trap_req),
        .pc_write(pc_write2), .ifid_write(ifid_write2), .idex_write(idex_write2),
        .exmem_write(exmem_write2), .ifid_flush(ifid_flush2), .idex_flush(idex_flush2),
        .pc_sel(pc_sel2), .trap_ack(trap_ack2), .state(state2), .stall_cycles(stall_cycles2)
    );

    // Control vector layout: {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, pc_sel, trap_ack, state}
    localparam logic [11:0] V_BOOT = 12'b0_1_1_1_1_1_00_0_000;
    localparam logic [11:0] V_RUN  = 12'b1_1_1_1_0_0_00_0_001;
    localparam logic [11:0] V_LU   = 12'b0_0_1_1_0_1_00_0_001;
    localparam logic [11:0] V_LS   = 12'b1_1_1_1_0_0_00_0_010;
    localparam logic [11:0] V_BR   = 12'b1_1_1_1_1_1_01_0_001;
    localparam logic [11:0] V_FRZ1 = 12'b0_0_0_0_0_0_00_0_001;
    localparam logic [11:0] V_FRZ3 = 12'b0_0_0_0_0_0_00_0_011;
    localparam logic [11:0] V_BR3  = 12'b1_1_1_1_1_1_01_0_011;
    localparam logic [11:0] V_TRQ  = 12'b0_1_1_1_1_1_00_0_001;
    localparam logic [11:0] V_DRN  = 12'b0_1_1_1_1_1_00_0_100;
    localparam logic [11:0] V_DFZ  = 12'b0_0_0_0_0_0_00_0_100;
    localparam logic [11:0] V_JMP  = 12'b1_1_1_1_1_1_10_1_101;
    localparam logic [11:0] V_MISS = 12'b0_1_1_1_1_0_00_0_001;

    typedef struct {
        logic [11:0] ctl;
        logic [15:0] st;
        logic [3:0]  st4;
        int          id;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_step = 0;

    // One cycle of stimulus; when chk is set, the expected response for this cycle is queued.
    task automatic step(input logic r, lu, br, busy, iv, tr,
                        input logic [11:0] ectl, input int es, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; load_use = lu; branch_taken = br; dmem_busy = busy;
        imem_valid = iv; trap_req = tr;
        n_step++;
        if (chk) begin
            e.ctl = ectl;
            e.st  = 16'(es);
            e.st4 = (es > 15) ? 4'd15 : 4'(es);
            e.id  = n_step;
            q.push_back(e);
        end
    endtask

    // Monitor: compares every queued expectation against the DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [11:0] act;
            logic [11:0] act4;
            e = q.pop_front();
            act  = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
                    pc_sel, trap_ack, state};
            act4 = {pc_write2, ifid_write2, idex_write2, exmem_write2, ifid_flush2, idex_flush2,
                    pc_sel2, trap_ack2, state2};
            n_vec++;
            if (act !== e.ctl) begin
                n_err++;
                $display("FAIL ctl step %0d: got %b want %b", e.id, act, e.ctl);
            end
            if (stall_cycles !== e.st) begin
                n_err++;
                $display("FAIL stall step %0d: got %0d want %0d", e.id, stall_cycles, e.st);
            end
            if (act4 !== e.ctl) begin
                n_err++;
                $display("FAIL ctl4 step %0d: got %b want %b", e.id, act4, e.ctl);
            end
            if (stall_cycles2 !== e.st4) begin
                n_err++;
                $display("FAIL stall4 step %0d: got %0d want %0d", e.id, stall_cycles2, e.st4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_BOOT, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_BOOT, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_BOOT, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN,  0, 1'b1);
        // load-use held two cycles: one bubble only
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, V_LU,   0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, V_LS,   1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN,  1, 1'b1);
        // branch beats load-use; branch with a fetch miss
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, V_BR,   1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN,  1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BR,   1, 1'b1);
        // dmem busy 4 cycles with branch pending, redirect on exit
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, V_FRZ1, 1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, V_FRZ3, 2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, V_FRZ3, 3, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, V_FRZ3, 4, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, V_BR3,  5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN,  5, 1'b1);
        // trap with one frozen drain cycle: ack 5 cycles after the request
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_TRQ,  5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, V_DFZ,  6, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, V_DRN,  7, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_DRN,  8, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_DRN,  9, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_JMP, 10, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN, 10, 1'b1);
        // fetch miss
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_MISS, 10, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN,  11, 1'b1);
        // reset during trap drain: back to BOOT, no ack
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_TRQ,  11, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_DRN,  12, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_BOOT, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_BOOT, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN,  0, 1'b1);
        // long fetch-miss run: the 4-bit counter saturates at 15
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_MISS, i, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN, 17, 1'b1);

        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
